// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: state encodings and default opcode ranges.
package cpu_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_FETCH    = 3'd0;
  localparam logic [STATE_W-1:0] ST_DECODE   = 3'd1;
  localparam logic [STATE_W-1:0] ST_EXECUTE  = 3'd2;
  localparam logic [STATE_W-1:0] ST_MEM_WAIT = 3'd3;
  localparam logic [STATE_W-1:0] ST_TRAP     = 3'd4;

  localparam int unsigned DEF_OPC_W       = 32;
  localparam int unsigned DEF_MEM_FIRST   = 27;
  localparam int unsigned DEF_MEM_LAST    = 34;
  localparam int unsigned DEF_STORE_FIRST = 31;
  localparam int unsigned DEF_TIMEOUT     = 255;

  localparam int unsigned INSTRET_W = 32;

  // States in which the sequencer owns the bus and waits for data-valid.
  function automatic logic is_bus_state(input logic [STATE_W-1:0] s);
    return (s == ST_FETCH) || (s == ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus-wait cycle counter; flags the last permitted wait cycle before a trap.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // A zero TIMEOUT disables the trap entirely.
  always_comb begin
    expired = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetch/decode/execute/memory-wait control with bus timeout trap
// and a retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned OPC_W       = DEF_OPC_W,
  parameter int unsigned MEM_FIRST   = DEF_MEM_FIRST,
  parameter int unsigned MEM_LAST    = DEF_MEM_LAST,
  parameter int unsigned STORE_FIRST = DEF_STORE_FIRST,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_bus_DV,
  input  logic [OPC_W-1:0]     i_instruction,
  input  logic                 i_stall,
  output logic [STATE_W-1:0]   o_state,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic                 o_load_IR,
  output logic                 o_load_PC,
  output logic                 o_trap,
  output logic [INSTRET_W-1:0] o_instret
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               is_store_q;
  logic               is_store_d;
  logic               load_ir_d;
  logic               load_pc_d;
  logic               is_mem_code;
  logic               is_store_code;
  logic               wd_clear;
  logic               wd_enable;
  logic               expired;

  always_comb begin
    is_mem_code   = (i_instruction >= OPC_W'(MEM_FIRST)) && (i_instruction <= OPC_W'(MEM_LAST));
    is_store_code = (i_instruction >= OPC_W'(STORE_FIRST)) && (i_instruction <= OPC_W'(MEM_LAST));
  end

  // Next-state and pulse generation; data-valid beats the timeout in bus states.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    load_ir_d  = 1'b0;
    load_pc_d  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (i_bus_DV) begin
          state_d   = ST_DECODE;
          load_ir_d = 1'b1;
        end else if (expired) begin
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (!i_stall) begin
          is_store_d = is_store_code;
          state_d    = is_mem_code ? ST_MEM_WAIT : ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (!i_stall) begin
          state_d   = ST_FETCH;
          load_pc_d = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (i_bus_DV) begin
          state_d   = ST_FETCH;
          load_pc_d = 1'b1;
        end else if (expired) begin
          state_d = ST_TRAP;
        end
      end
      ST_TRAP: state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    wd_clear  = (state_d != state_q);
    wd_enable = is_bus_state(state_q) && !i_bus_DV;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_FETCH;
      is_store_q <= 1'b0;
      o_load_IR  <= 1'b0;
      o_load_PC  <= 1'b0;
      o_instret  <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      o_load_IR  <= load_ir_d;
      o_load_PC  <= load_pc_d;
      if (load_pc_d) begin
        o_instret <= o_instret + INSTRET_W'(1);
      end
    end
  end

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_bus_watchdog (
    .clk     (i_clk),
    .rst     (i_rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (expired)
  );

  always_comb begin
    o_state   = state_q;
    o_mem_req = is_bus_state(state_q);
    o_mem_we  = (state_q == ST_MEM_WAIT) && is_store_q;
    o_trap    = (state_q == ST_TRAP);
  end

endmodule
